regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Ports SHALL be, one per line (name, direction, width, meaning); clock and reset first:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- alu_valid  input  1  ALU writeback request.
- alu_wa  input  4  ALU destination register.
- alu_wd  input  32  ALU write data.
- alu_ready  output  1  ALU request accepted this cycle.
- mem_valid  input  1  load writeback request.
- mem_wa  input  4  load destination register.
- mem_wd  input  32  load write data.
- mem_ready  output  1  load request accepted this cycle.
- we3  output  1  register-file write enable.
- wa3  output  4  register-file write address.
- wd3  output  32  register-file write data.
- pend  output  15  one-hot mask of r0-r14 being written this cycle.
- r15_drop  output  1  pulse: accepted write targeted r15 and was discarded.
REQ-002 reset is synchronous and active-low: state clears on a rising clk edge while reset=0.

Function
REQ-003 At most one request SHALL be accepted per cycle: at most one of alu_ready and mem_ready is 1.
REQ-004 Ready SHALL be combinational from valid and arbitration state; a request is accepted when valid=1 and ready=1.
REQ-005 A requester with valid=0 SHALL never receive ready=1.
REQ-006 An accepted request SHALL be registered so that we3, wa3 and wd3 present it in the next cycle (1-cycle latency).
REQ-007 we3 SHALL be 0 in any cycle following a cycle with no acceptance.
REQ-008 An accepted request with wa=4'hF SHALL give we3=0 and r15_drop=1 for that one cycle; wa3 and wd3 still carry the request.
REQ-009 pend SHALL equal the one-hot decode of wa3 when we3=1, else 15'b0.
REQ-010 Default arbitration SHALL be fixed priority, mem over alu.
REQ-011 Starvation counter starv (2 bits, saturating):
- increments in any cycle alu_valid=1 and alu_ready=0;
- clears when alu is accepted.
REQ-012 When starv=3 and alu_valid=1, alu SHALL be granted over mem for that cycle.
REQ-013 Same destination on both requesters in one cycle: winner written first, loser the next accepted cycle. The register's final value is the loser's data.
REQ-014 Valid and payload SHALL be held stable by the requester until accepted; the block does not check this.
REQ-015 Back-to-back acceptances SHALL be supported every cycle; no bubble is inserted.

Reset
REQ-016 While reset=0: we3=0, wa3=4'h0, wd3=32'h0, pend=0, r15_drop=0, starv=0, round-robin pointer = mem.
REQ-017 While reset=0: alu_ready=0 and mem_ready=0.
REQ-018 A request presented during reset SHALL NOT be accepted and SHALL NOT be written later.
REQ-019 A staged write pending when reset asserts SHALL be discarded (we3=0 next cycle).

Configuration
REQ-020 Macro WB_RR_EN selects the arbitration policy:
- Defined: strict round-robin; when both are valid, grant goes to the requester not granted last; the pointer updates only on acceptance; starv is held at 0 and REQ-010/REQ-012 do not apply.
- Undefined: REQ-010 to REQ-012 apply.

Verification
REQ-021 Single ALU request, alu_wa=3, alu_wd=32'hDEADBEEF -> alu_ready=1 in cycle N; we3=1, wa3=3, wd3=32'hDEADBEEF and pend=15'h0008 in N+1.
REQ-022 Both valid continuously, macro undefined -> grant pattern mem,mem,mem,alu, repeating; starv reaches 3 before each alu grant. Macro defined -> grant pattern alternates mem,alu,mem,alu.
REQ-023 mem_wa=15, mem_wd=32'h1234 accepted -> next cycle we3=0, r15_drop=1, pend=0.
REQ-024 Same cycle alu_wa=5/32'hA and mem_wa=5/32'hB, macro undefined -> we3 writes 5<-32'hB, then 5<-32'hA; final r5=32'hA.
REQ-025 reset=0 asserted while a write is staged and both requesters valid -> next cycle we3=0, both readies 0, starv=0. After reset=1, first grant is to mem.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: merges ALU and load writebacks into one write port.
// Fixed priority (mem over alu) with anti-starvation by default; define WB_RR_EN for strict round-robin.
module regfile_wb_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [3:0]  alu_wa,
  input  logic [31:0] alu_wd,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [3:0]  mem_wa,
  input  logic [31:0] mem_wd,
  output logic        mem_ready,
  output logic        we3,
  output logic [3:0]  wa3,
  output logic [31:0] wd3,
  output logic [14:0] pend,
  output logic        r15_drop
);

  // Handshake: a requester holds valid and payload until it sees ready=1 in the
  // same cycle; ready is combinational and never asserted without valid or in reset.

  logic [1:0]  starv;
  logic        alu_grant;
  logic        mem_grant;
  logic        any_grant;
  logic [3:0]  sel_wa;
  logic [31:0] sel_wd;

`ifdef WB_RR_EN
  logic rr_mem;

  always_comb begin
    alu_grant = 1'b0;
    mem_grant = 1'b0;
    if (reset) begin
      if (alu_valid && mem_valid) begin
        mem_grant = rr_mem;
        alu_grant = !rr_mem;
      end else begin
        alu_grant = alu_valid;
        mem_grant = mem_valid;
      end
    end
  end
`else
  always_comb begin
    alu_grant = 1'b0;
    mem_grant = 1'b0;
    if (reset) begin
      // A saturated starvation count lets the ALU jump ahead of a waiting load.
      if (alu_valid && (starv == 2'd3 || !mem_valid)) begin
        alu_grant = 1'b1;
      end else if (mem_valid) begin
        mem_grant = 1'b1;
      end
    end
  end
`endif

  assign alu_ready = alu_grant;
  assign mem_ready = mem_grant;
  assign any_grant = alu_grant || mem_grant;
  assign sel_wa    = mem_grant ? mem_wa : alu_wa;
  assign sel_wd    = mem_grant ? mem_wd : alu_wd;

  always_ff @(posedge clk) begin
    if (!reset) begin
      we3      <= 1'b0;
      wa3      <= 4'h0;
      wd3      <= 32'h0;
      r15_drop <= 1'b0;
    end else begin
      // r15 is not a real register: the slot is consumed but nothing is written.
      we3      <= any_grant && (sel_wa != 4'hF);
      r15_drop <= any_grant && (sel_wa == 4'hF);
      if (any_grant) begin
        wa3 <= sel_wa;
        wd3 <= sel_wd;
      end
    end
  end

`ifdef WB_RR_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_mem <= 1'b1;
      starv  <= 2'd0;
    end else begin
      starv <= 2'd0;
      if (mem_grant) begin
        rr_mem <= 1'b0;
      end else if (alu_grant) begin
        rr_mem <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      assert (starv == 2'd0);
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!reset) begin
      starv <= 2'd0;
    end else if (alu_grant) begin
      starv <= 2'd0;
    end else if (alu_valid && starv != 2'd3) begin
      starv <= starv + 2'd1;
    end
  end
`endif

  always_comb begin
    pend = '0;
    for (int i = 0; i < 15; i++) begin
      pend[i] = we3 && (wa3 == 4'(i));
    end
  end

  always_ff @(posedge clk) begin
    assert (!(alu_ready && mem_ready));
    assert (!(alu_ready && !alu_valid));
    assert (!(mem_ready && !mem_valid));
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: per-cycle model comparison plus directed literal checks.
// Build with +define+WB_RR_EN to exercise the round-robin policy.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        alu_valid = 1'b0;
  logic [3:0]  alu_wa = 4'h0;
  logic [31:0] alu_wd = 32'h0;
  logic        alu_ready;
  logic        mem_valid = 1'b0;
  logic [3:0]  mem_wa = 4'h0;
  logic [31:0] mem_wd = 32'h0;
  logic        mem_ready;
  logic        we3;
  logic [3:0]  wa3;
  logic [31:0] wd3;
  logic [14:0] pend;
  logic        r15_drop;

  int n_vec = 0;
  int n_err = 0;

  regfile_wb_arbiter dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_wa(alu_wa), .alu_wd(alu_wd), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_wa(mem_wa), .mem_wd(mem_wd), .mem_ready(mem_ready),
    .we3(we3), .wa3(wa3), .wd3(wd3), .pend(pend), .r15_drop(r15_drop)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_starv = 0;
  bit          m_rr_mem = 1'b1;
  bit          m_we = 1'b0;
  bit          m_drop = 1'b0;
  logic [3:0]  m_wa = 4'h0;
  logic [31:0] m_wd = 32'h0;
  logic [31:0] dut_rf [16];

  always @(negedge clk) begin : cmp
    bit          g_alu;
    bit          g_mem;
    logic [14:0] e_pend;
    logic [3:0]  w_a;
    logic [31:0] w_d;
    g_alu = 1'b0;
    g_mem = 1'b0;
    if (reset) begin
      if (alu_valid && mem_valid) begin
`ifdef WB_RR_EN
        g_mem = m_rr_mem;
`else
        g_mem = (m_starv != 3);
`endif
        g_alu = !g_mem;
      end else begin
        g_alu = alu_valid;
        g_mem = mem_valid;
      end
    end
    e_pend = m_we ? 15'(32'd1 << m_wa) : 15'd0;

    check("m_alu_ready", 32'(alu_ready), 32'(g_alu));
    check("m_mem_ready", 32'(mem_ready), 32'(g_mem));
    check("m_we3", 32'(we3), 32'(m_we));
    check("m_r15_drop", 32'(r15_drop), 32'(m_drop));
    check("m_pend", 32'(pend), 32'(e_pend));
    check("m_starv", 32'(dut.starv), 32'(m_starv));
    if (m_we || m_drop) begin
      check("m_wa3", 32'(wa3), 32'(m_wa));
      check("m_wd3", wd3, m_wd);
    end
    if (we3) dut_rf[wa3] = wd3;

    if (!reset) begin
      m_starv  = 0;
      m_rr_mem = 1'b1;
      m_we     = 1'b0;
      m_drop   = 1'b0;
    end else begin
      w_a    = g_mem ? mem_wa : alu_wa;
      w_d    = g_mem ? mem_wd : alu_wd;
      m_we   = (g_alu || g_mem) && (w_a != 4'hF);
      m_drop = (g_alu || g_mem) && (w_a == 4'hF);
      if (g_alu || g_mem) begin
        m_wa = w_a;
        m_wd = w_d;
      end
`ifndef WB_RR_EN
      if (g_alu) m_starv = 0;
      else if (alu_valid && m_starv < 3) m_starv = m_starv + 1;
`endif
      if (g_mem) m_rr_mem = 1'b0;
      if (g_alu) m_rr_mem = 1'b1;
    end
  end

  // ---------------- directed stimulus ----------------
  bit          exp_alu [8];
  logic [3:0]  s_alu_wa [5];
  logic [31:0] s_alu_wd [5];
  logic [3:0]  s_mem_wa [4];
  logic [31:0] s_mem_wd [4];

  initial begin
    int ai;
    int mi;
    int cyc;
    for (int i = 0; i < 16; i++) dut_rf[i] = 32'h0;
`ifdef WB_RR_EN
    exp_alu = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_alu = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
`endif
    s_alu_wa = '{4'd1, 4'd2, 4'd15, 4'd4, 4'd4};
    s_alu_wd = '{32'd11, 32'd12, 32'd13, 32'd14, 32'd15};
    s_mem_wa = '{4'd4, 4'd5, 4'd15, 4'd6};
    s_mem_wd = '{32'd21, 32'd22, 32'd23, 32'd24};

    // reset state with a request presented during reset
    reset = 1'b0;
    alu_valid = 1'b1; alu_wa = 4'd9; alu_wd = 32'h99;
    @(negedge clk);
    check("rst_alu_ready", 32'(alu_ready), 32'd0);
    check("rst_we3", 32'(we3), 32'd0);
    check("rst_wa3", 32'(wa3), 32'd0);
    check("rst_wd3", wd3, 32'd0);
    check("rst_pend", 32'(pend), 32'd0);
    tick();
    alu_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("rst_no_late_write", 32'(we3), 32'd0);

    // single ALU write
    tick();
    alu_valid = 1'b1; alu_wa = 4'd3; alu_wd = 32'hDEADBEEF;
    @(negedge clk);
    check("single_alu_ready", 32'(alu_ready), 32'd1);
    check("single_mem_ready", 32'(mem_ready), 32'd0);
    tick();
    alu_valid = 1'b0;
    @(negedge clk);
    check("single_we3", 32'(we3), 32'd1);
    check("single_wa3", 32'(wa3), 32'd3);
    check("single_wd3", wd3, 32'hDEADBEEF);
    check("single_pend", 32'(pend), 32'h0008);
    tick();
    @(negedge clk);
    check("idle_we3", 32'(we3), 32'd0);

    // both requesters valid continuously
    do_reset();
    alu_valid = 1'b1; alu_wa = 4'd1; alu_wd = 32'h100;
    mem_valid = 1'b1; mem_wa = 4'd2; mem_wd = 32'h200;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("pat_alu", 32'(alu_ready), 32'(exp_alu[i]));
      check("pat_mem", 32'(mem_ready), 32'(!exp_alu[i]));
`ifndef WB_RR_EN
      if (exp_alu[i]) check("pat_starv", 32'(dut.starv), 32'd3);
`endif
      tick();
    end
    alu_valid = 1'b0;
    mem_valid = 1'b0;

    // write to r15 is dropped
    do_reset();
    mem_valid = 1'b1; mem_wa = 4'hF; mem_wd = 32'h1234;
    @(negedge clk);
    check("r15_mem_ready", 32'(mem_ready), 32'd1);
    tick();
    mem_valid = 1'b0;
    @(negedge clk);
    check("r15_we3", 32'(we3), 32'd0);
    check("r15_drop", 32'(r15_drop), 32'd1);
    check("r15_pend", 32'(pend), 32'd0);
    check("r15_wa3", 32'(wa3), 32'hF);
    check("r15_wd3", wd3, 32'h1234);
    tick();
    @(negedge clk);
    check("r15_drop_pulse", 32'(r15_drop), 32'd0);

    // same destination from both requesters
    do_reset();
    dut_rf[5] = 32'h0;
    alu_valid = 1'b1; alu_wa = 4'd5; alu_wd = 32'hA;
    mem_valid = 1'b1; mem_wa = 4'd5; mem_wd = 32'hB;
    @(negedge clk);
    check("same_mem_first", 32'(mem_ready), 32'd1);
    tick();
    mem_valid = 1'b0;
    @(negedge clk);
    check("same_w1_wa3", 32'(wa3), 32'd5);
    check("same_w1_wd3", wd3, 32'hB);
    check("same_alu_next", 32'(alu_ready), 32'd1);
    tick();
    alu_valid = 1'b0;
    @(negedge clk);
    check("same_w2_wd3", wd3, 32'hA);
    tick();
    @(negedge clk);
    check("same_final_r5", dut_rf[5], 32'hA);

    // reset while a write is staged and both requesters valid
    do_reset();
    alu_valid = 1'b1; alu_wa = 4'd6; alu_wd = 32'h66;
    mem_valid = 1'b1; mem_wa = 4'd7; mem_wd = 32'h77;
    @(negedge clk);
    check("rs_mem_ready", 32'(mem_ready), 32'd1);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rs_alu_ready_0", 32'(alu_ready), 32'd0);
    check("rs_mem_ready_0", 32'(mem_ready), 32'd0);
    tick();
    @(negedge clk);
    check("rs_we3_cleared", 32'(we3), 32'd0);
    check("rs_starv_cleared", 32'(dut.starv), 32'd0);
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("rs_first_mem", 32'(mem_ready), 32'd1);
    check("rs_first_not_alu", 32'(alu_ready), 32'd0);
    tick();
    alu_valid = 1'b0;
    mem_valid = 1'b0;

    // back-to-back streams from both requesters
    do_reset();
    dut_rf[4] = 32'h0;
    ai = 0;
    mi = 0;
    cyc = 0;
    while ((ai < 5 || mi < 4) && cyc < 40) begin
      alu_valid = (ai < 5);
      if (ai < 5) begin alu_wa = s_alu_wa[ai]; alu_wd = s_alu_wd[ai]; end
      mem_valid = (mi < 4);
      if (mi < 4) begin mem_wa = s_mem_wa[mi]; mem_wd = s_mem_wd[mi]; end
      @(negedge clk);
      if (alu_valid && alu_ready) ai++;
      if (mem_valid && mem_ready) mi++;
      cyc++;
      tick();
    end
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    check("stream_drained", 32'(ai * 10 + mi), 32'd54);
    check("stream_cycles", 32'(cyc), 32'd9);
    tick();
    @(negedge clk);
    check("stream_final_r4", dut_rf[4], 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
